// File: rtl/instruction_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instruction_sequencer_pkg
// Purpose : Shared constants for the instruction sequencer: opcodes, output
//           selectors, FSM state encodings and instruction field offsets.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package instruction_sequencer_pkg;

    // Instruction field layout: [15:11] opcode, [10:8] selector, [7:0] address
    localparam int INSTR_W      = 16;
    localparam int OP_W         = 5;
    localparam int SEL_W        = 3;
    localparam int OP_LSB       = 11;
    localparam int SEL_LSB      = 8;

    // Opcodes
    localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
    localparam logic [OP_W-1:0] OP_PRINT = 5'b00001;
    localparam logic [OP_W-1:0] OP_LOAD  = 5'b00010;
    localparam logic [OP_W-1:0] OP_STORE = 5'b00011;
    localparam logic [OP_W-1:0] OP_EOP   = 5'b00100;
    localparam logic [OP_W-1:0] OP_LT    = 5'b01000;
    localparam logic [OP_W-1:0] OP_GT    = 5'b01001;
    localparam logic [OP_W-1:0] OP_JUMP  = 5'b01100;
    localparam logic [OP_W-1:0] OP_BEQ   = 5'b01101;
    localparam logic [OP_W-1:0] OP_BNE   = 5'b01110;
    localparam logic [OP_W-1:0] OP_ADD   = 5'b10000;
    localparam logic [OP_W-1:0] OP_SUB   = 5'b10001;
    localparam logic [OP_W-1:0] OP_OR    = 5'b10010;
    localparam logic [OP_W-1:0] OP_AND   = 5'b10011;

    // Output selectors: which architectural register the ALU result targets
    localparam logic [SEL_W-1:0] SEL_NONE = 3'b000;
    localparam logic [SEL_W-1:0] SEL_ACC  = 3'b001;
    localparam logic [SEL_W-1:0] SEL_PC   = 3'b010;
    localparam logic [SEL_W-1:0] SEL_MEM  = 3'b011;
    localparam logic [SEL_W-1:0] SEL_SEG  = 3'b100;

    // FSM states
    localparam logic [2:0] ST_FETCH      = 3'd0;
    localparam logic [2:0] ST_FETCH_WAIT = 3'd1;
    localparam logic [2:0] ST_DECODE     = 3'd2;
    localparam logic [2:0] ST_READ_WAIT  = 3'd3;
    localparam logic [2:0] ST_EXEC       = 3'd4;
    localparam logic [2:0] ST_COMMIT     = 3'd5;
    localparam logic [2:0] ST_HALT       = 3'd6;

    // Branch decision given the current condition flag
    function automatic logic branch_taken(input logic [OP_W-1:0] op, input logic flag);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_JUMP: taken = 1'b1;
            OP_BEQ:  taken = flag;
            OP_BNE:  taken = ~flag;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage : instruction_sequencer_pkg
`default_nettype wire

// File: rtl/instruction_sequencer_exec_timer.sv
`default_nettype none
// ============================================================================
// Module  : instruction_sequencer_exec_timer
// Purpose : Loadable down-counter timing the execute window. DoneOutput is
//           high in the CYCLES-th enabled cycle after a load.
// Ports   : clkInput/rstInput  clock, async active-high reset
//           LoadInput          (re)arm the counter
//           EnableInput        count while high (EXEC state)
//           DoneOutput         last cycle of the window
// Rev     : 1.0  initial release
// ============================================================================
module instruction_sequencer_exec_timer #(
    parameter int CYCLES = 4
) (
    input  logic clkInput,
    input  logic rstInput,
    input  logic LoadInput,
    input  logic EnableInput,
    output logic DoneOutput
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (LoadInput) begin
            count_d = CNT_W'(CYCLES - 1);
        end else if (EnableInput && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clkInput or posedge rstInput) begin
        if (rstInput) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign DoneOutput = EnableInput && (count_q == '0);

endmodule : instruction_sequencer_exec_timer
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : instruction_sequencer
// Purpose : Fetch/decode/commit control stage in front of the ALU. Fetches an
//           instruction, reads its data word, holds operands for EXEC_CYCLES,
//           then commits ALU results to PC/acc/flag/RAM/display; halts on EOP.
// Ports   : clkInput, rstInput                 clock, async reset
//           InstructionInput/ProgramAddressOutput  program ROM
//           DataReadInput/DataAddressOutput/DataWriteEnableOutput/
//           DataWriteOutput                       data RAM
//           OperandOutput..ConditionFlagReadOutput  operands to ALU
//           Alu*Input                             results from ALU
//           OutputBinaryOutput, HaltOutput        display value, halted
// Rev     : 1.0  initial release
// ============================================================================
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int EXEC_CYCLES = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16
) (
    input  logic              clkInput,
    input  logic              rstInput,
    input  logic [INSTR_W-1:0] InstructionInput,
    output logic [ADDR_W-1:0] ProgramAddressOutput,
    input  logic [DATA_W-1:0] DataReadInput,
    output logic [ADDR_W-1:0] DataAddressOutput,
    output logic              DataWriteEnableOutput,
    output logic [DATA_W-1:0] DataWriteOutput,
    output logic [OP_W-1:0]   OperandOutput,
    output logic [SEL_W-1:0]  OutputSelectorOutput,
    output logic [DATA_W-1:0] AccumulatorReadOutput,
    output logic [DATA_W-1:0] DataOperandOutput,
    output logic              ConditionFlagReadOutput,
    input  logic              AluConditionFlagInput,
    input  logic              AluEndFlagInput,
    input  logic [ADDR_W-1:0] AluProgramCounterInput,
    input  logic [DATA_W-1:0] AluAccumulatorInput,
    input  logic [DATA_W-1:0] AluDataInput,
    input  logic [DATA_W-1:0] AluOutputBinaryInput,
    output logic [DATA_W-1:0] OutputBinaryOutput,
    output logic              HaltOutput
);

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               flag_q, flag_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic               halt_q, halt_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  dop_q, dop_d;

    logic               timer_load;
    logic               timer_done;
    logic               exec_active;

    // Halting is decided from the decoded opcode; the ALU's end flag is
    // redundant with it and intentionally not consumed.
    logic               unused_end_flag;
    assign unused_end_flag = AluEndFlagInput;

    wire [OP_W-1:0]  op  = instr_q[OP_LSB +: OP_W];
    wire [SEL_W-1:0] sel = instr_q[SEL_LSB +: SEL_W];

    assign exec_active = (state_q == ST_EXEC);

    instruction_sequencer_exec_timer #(
        .CYCLES (EXEC_CYCLES)
    ) u_exec_timer (
        .clkInput    (clkInput),
        .rstInput    (rstInput),
        .LoadInput   (timer_load),
        .EnableInput (exec_active),
        .DoneOutput  (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        flag_d     = flag_q;
        out_d      = out_q;
        halt_d     = halt_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        instr_d    = instr_q;
        dop_d      = dop_q;
        timer_load = 1'b0;

        case (state_q)
            ST_FETCH:      state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: state_d = ST_DECODE;
            ST_DECODE: begin
                instr_d = InstructionInput;
                state_d = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                dop_d      = DataReadInput;
                timer_load = 1'b1;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                // ALU results are sampled on the edge that ends the execute
                // window, while operands are still held, so that the updated
                // registers and the write strobe are visible in COMMIT.
                if (timer_done) begin
                    state_d = ST_COMMIT;
                    if (sel == SEL_ACC) acc_d = AluAccumulatorInput;
                    if (sel == SEL_SEG) out_d = AluOutputBinaryInput;
                    if (sel == SEL_MEM) begin
                        we_d    = 1'b1;
                        wdata_d = AluDataInput;
                    end
                    if ((op == OP_LT) || (op == OP_GT)) flag_d = AluConditionFlagInput;
                    if (op == OP_EOP) begin
                        halt_d = 1'b1;
                    end else if ((sel == SEL_PC) && branch_taken(op, flag_q)) begin
                        pc_d = AluProgramCounterInput;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            ST_COMMIT:     state_d = (op == OP_EOP) ? ST_HALT : ST_FETCH;
            ST_HALT:       state_d = ST_HALT;
            default:       state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clkInput or posedge rstInput) begin
        if (rstInput) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
            flag_q  <= 1'b0;
            out_q   <= '0;
            halt_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            instr_q <= '0;
            dop_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            flag_q  <= flag_d;
            out_q   <= out_d;
            halt_q  <= halt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            dop_q   <= dop_d;
        end
    end

    assign ProgramAddressOutput    = pc_q;
    // In DECODE the instruction register is not loaded yet, so the address
    // comes straight from ROM data to start the RAM read one cycle earlier.
    assign DataAddressOutput       = (state_q == ST_DECODE) ? InstructionInput[ADDR_W-1:0]
                                                            : instr_q[ADDR_W-1:0];
    assign DataWriteEnableOutput   = we_q;
    assign DataWriteOutput         = wdata_q;
    assign OperandOutput           = exec_active ? op  : OP_NOP;
    assign OutputSelectorOutput    = exec_active ? sel : SEL_NONE;
    assign AccumulatorReadOutput   = acc_q;
    assign DataOperandOutput       = dop_q;
    assign ConditionFlagReadOutput = flag_q;
    assign OutputBinaryOutput      = out_q;
    assign HaltOutput              = halt_q;

endmodule : instruction_sequencer
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_sequencer
// Purpose : Self-checking bench: synchronous ROM/RAM and a small ALU around
//           the sequencer, an instruction-level reference model checked
//           every cycle, plus directed literal expectations.
// Rev     : 1.0  initial release
// ============================================================================
module tb_instruction_sequencer;

    localparam int EXEC = 4;
    localparam int LAST = 4 + EXEC;   // cycle index of COMMIT within an instruction

    localparam logic [4:0] NOP = 5'b00000, PRINT = 5'b00001, LOAD = 5'b00010,
                           STORE = 5'b00011, EOP = 5'b00100, LT = 5'b01000,
                           GT = 5'b01001, JUMP = 5'b01100, BEQ = 5'b01101,
                           BNE = 5'b01110, ADD = 5'b10000, SUB = 5'b10001,
                           ORR = 5'b10010, ANDD = 5'b10011, UNK = 5'b11111;
    localparam logic [2:0] S_NONE = 3'd0, S_ACC = 3'd1, S_PC = 3'd2,
                           S_MEM = 3'd3, S_SEG = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rom_rd = '0, ram_rd = '0;
    logic [7:0]  pa, da, alu_pc;
    logic        we, flag_rd, alu_flag, alu_end, halt;
    logic [15:0] wd, acc_rd, dop, alu_acc, alu_data, alu_out, outb;
    logic [4:0]  opnd;
    logic [2:0]  osel;

    logic [15:0] rom [0:255];
    logic [15:0] ram [0:255];

    int n_chk = 0, n_fail = 0;
    int gcyc = 0, rel = 0;
    logic chk_en = 1'b0;

    // Reference model: architectural state plus position in the instruction
    logic [7:0]  m_pc;
    logic [15:0] m_acc, m_out;
    logic        m_flag, m_halt;
    int          ph;

    always #5 clk = ~clk;
    always @(posedge clk) gcyc <= gcyc + 1;

    // Synchronous memories: data valid one cycle after the address
    always @(posedge clk) begin
        rom_rd <= rom[pa];
        ram_rd <= ram[da];
    end

    // Behavioural ALU
    function automatic logic [15:0] f_acc(input logic [4:0] op, input logic [15:0] a, input logic [15:0] d);
        case (op)
            LOAD:    return d;
            ADD:     return a + d;
            SUB:     return a - d;
            ORR:     return a | d;
            ANDD:    return a & d;
            default: return a;
        endcase
    endfunction

    function automatic logic f_flag(input logic [4:0] op, input logic [15:0] a, input logic [15:0] d, input logic f);
        if (op == LT) return a < d;
        if (op == GT) return a > d;
        return f;
    endfunction

    function automatic logic f_taken(input logic [4:0] op, input logic f);
        if (op == JUMP) return 1'b1;
        if (op == BEQ)  return f;
        if (op == BNE)  return !f;
        return 1'b0;
    endfunction

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [2:0] s, input logic [7:0] a);
        return {op, s, a};
    endfunction

    assign alu_acc  = f_acc(opnd, acc_rd, dop);
    assign alu_flag = f_flag(opnd, acc_rd, dop, flag_rd);
    assign alu_end  = (opnd == EOP);
    assign alu_pc   = dop[7:0];
    assign alu_data = acc_rd;
    assign alu_out  = acc_rd;

    instruction_sequencer #(
        .EXEC_CYCLES (EXEC),
        .ADDR_W      (8),
        .DATA_W      (16)
    ) dut (
        .clkInput                (clk),
        .rstInput                (rst),
        .InstructionInput        (rom_rd),
        .ProgramAddressOutput    (pa),
        .DataReadInput           (ram_rd),
        .DataAddressOutput       (da),
        .DataWriteEnableOutput   (we),
        .DataWriteOutput         (wd),
        .OperandOutput           (opnd),
        .OutputSelectorOutput    (osel),
        .AccumulatorReadOutput   (acc_rd),
        .DataOperandOutput       (dop),
        .ConditionFlagReadOutput (flag_rd),
        .AluConditionFlagInput   (alu_flag),
        .AluEndFlagInput         (alu_end),
        .AluProgramCounterInput  (alu_pc),
        .AluAccumulatorInput     (alu_acc),
        .AluDataInput            (alu_data),
        .AluOutputBinaryInput    (alu_out),
        .OutputBinaryOutput      (outb),
        .HaltOutput              (halt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: one instruction spans LAST+1 cycles; at the COMMIT
    // cycle the model retires the instruction and outputs show the new state.
    logic [15:0] cur, c_d, e_wd;
    logic [4:0]  c_op;
    logic [2:0]  c_sel;
    logic [7:0]  c_ad;
    logic        e_we;
    logic        exec_win;
    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst && chk_en) begin
                cur   = rom[m_pc];
                c_op  = cur[15:11];
                c_sel = cur[10:8];
                c_ad  = cur[7:0];
                c_d   = ram[c_ad];
                e_we  = 1'b0;
                e_wd  = 16'h0;
                if (!m_halt && ph == LAST) begin
                    e_we = (c_sel == S_MEM);
                    e_wd = m_acc;
                    if (c_op == EOP)                             m_halt = 1'b1;
                    else if (c_sel == S_PC && f_taken(c_op, m_flag)) m_pc = c_d[7:0];
                    else                                         m_pc = m_pc + 8'd1;
                    m_flag = f_flag(c_op, m_acc, c_d, m_flag);
                    if (c_sel == S_SEG) m_out = m_acc;
                    if (c_sel == S_ACC) m_acc = f_acc(c_op, m_acc, c_d);
                end
                exec_win = !m_halt && ph >= 4 && ph < LAST;
                chk("pc", pa, m_pc);
                chk("acc", acc_rd, m_acc);
                chk("flag", flag_rd, m_flag);
                chk("outbin", outb, m_out);
                chk("halt", halt, m_halt);
                chk("we", we, e_we);
                chk("operand", opnd, exec_win ? c_op : 5'd0);
                chk("selector", osel, exec_win ? c_sel : 3'd0);
                if (exec_win) chk("dataop", dop, c_d);
                if (ph >= 2)  chk("daddr", da, c_ad);
                if (e_we)     chk("wdata", wd, e_wd);
                if (!m_halt) ph = (ph == LAST) ? 0 : ph + 1;
            end
        end
    end

    task automatic at_cycle(input int c);
        do @(negedge clk); while (gcyc < rel + c);
        #1;
    endtask

    task automatic assert_rst();
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        rst    = 1'b1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        m_pc = 8'h0; m_acc = 16'h0; m_out = 16'h0; m_flag = 1'b0; m_halt = 1'b0; ph = 0;
        rst    = 1'b0;
        rel    = gcyc;
        chk_en = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'h0;
            ram[i] = 16'h0;
        end
    endtask

    initial begin : stimulus
        // ---------------- Program A: ALU ops, store, print, branches, wrap
        clear_mem();
        rom[8'h00] = ins(LOAD,  S_ACC,  8'h01);
        rom[8'h01] = ins(ADD,   S_ACC,  8'h05);
        rom[8'h02] = ins(LOAD,  S_ACC,  8'h02);
        rom[8'h03] = ins(STORE, S_MEM,  8'h20);
        rom[8'h04] = ins(PRINT, S_SEG,  8'h00);
        rom[8'h05] = ins(LT,    S_NONE, 8'h06);
        rom[8'h06] = ins(BEQ,   S_PC,   8'h07);
        rom[8'h40] = ins(BNE,   S_PC,   8'h07);
        rom[8'h41] = ins(GT,    S_NONE, 8'h06);
        rom[8'h42] = ins(BEQ,   S_PC,   8'h07);
        rom[8'h43] = ins(BNE,   S_PC,   8'h08);
        rom[8'hFF] = ins(UNK,   S_NONE, 8'h00);
        ram[8'h01] = 16'd3;
        ram[8'h05] = 16'd7;
        ram[8'h02] = 16'hBEEF;
        ram[8'h06] = 16'hFFFF;
        ram[8'h07] = 16'h0040;
        ram[8'h08] = 16'h00FF;
        repeat (2) @(posedge clk);
        release_rst();
        at_cycle(0);   chk("A reset pc", pa, 8'h00);
                       chk("A reset acc", acc_rd, 16'h0);
                       chk("A reset halt", halt, 1'b0);
        at_cycle(8);   chk("A load acc", acc_rd, 16'd3);
                       chk("A load pc", pa, 8'h01);
        at_cycle(12);  chk("A readwait op", opnd, 5'd0);
        at_cycle(13);  chk("A exec op", opnd, ADD);
                       chk("A exec sel", osel, S_ACC);
        at_cycle(17);  chk("A add acc", acc_rd, 16'd10);
                       chk("A add pc", pa, 8'h02);
        at_cycle(34);  chk("A pre-store we", we, 1'b0);
        at_cycle(35);  chk("A store we", we, 1'b1);
                       chk("A store addr", da, 8'h20);
                       chk("A store data", wd, 16'hBEEF);
        at_cycle(36);  chk("A post-store we", we, 1'b0);
        at_cycle(44);  chk("A print out", outb, 16'hBEEF);
        at_cycle(53);  chk("A lt flag", flag_rd, 1'b1);
        at_cycle(62);  chk("A beq taken pc", pa, 8'h40);
        at_cycle(71);  chk("A bne not-taken pc", pa, 8'h41);
        at_cycle(80);  chk("A gt flag", flag_rd, 1'b0);
        at_cycle(89);  chk("A beq not-taken pc", pa, 8'h43);
        at_cycle(98);  chk("A bne taken pc", pa, 8'hFF);
        at_cycle(107); chk("A wrap pc", pa, 8'h00);
        at_cycle(108); chk("A wrap fetch", pa, 8'h00);

        // ---------------- Program C: reset in the middle of a STORE's EXEC
        assert_rst();
        clear_mem();
        rom[8'h00] = ins(LOAD,  S_ACC, 8'h01);
        rom[8'h01] = ins(STORE, S_MEM, 8'h20);
        ram[8'h01] = 16'd3;
        release_rst();
        at_cycle(8);   chk("C load acc", acc_rd, 16'd3);
        at_cycle(14);  chk("C exec sel", osel, S_MEM);
        assert_rst();  // cycle 15: inside the STORE execute window
        #1;
        chk("C rst we", we, 1'b0);
        chk("C rst pc", pa, 8'h00);
        chk("C rst acc", acc_rd, 16'h0);
        chk("C rst op", opnd, 5'd0);
        chk("C rst sel", osel, 3'd0);
        chk("C rst flag", flag_rd, 1'b0);
        chk("C rst out", outb, 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("C in-rst we", we, 1'b0);
        end
        release_rst();
        at_cycle(0);   chk("C rel fetch", pa, 8'h00);
        at_cycle(2);   chk("C rel fetch+2", pa, 8'h00);
        at_cycle(8);   chk("C rerun acc", acc_rd, 16'd3);
        at_cycle(20);

        // ---------------- Program B: EOP at PC=3 then 100 frozen cycles
        assert_rst();
        clear_mem();
        rom[8'h00] = ins(LOAD,  S_ACC,  8'h01);
        rom[8'h01] = ins(NOP,   S_NONE, 8'h00);
        rom[8'h02] = ins(PRINT, S_SEG,  8'h00);
        rom[8'h03] = ins(EOP,   S_NONE, 8'h00);
        ram[8'h01] = 16'd3;
        release_rst();
        at_cycle(34);  chk("B pre-eop halt", halt, 1'b0);
        at_cycle(35);  chk("B eop halt", halt, 1'b1);
                       chk("B eop pc", pa, 8'h03);
        at_cycle(140); chk("B halted", halt, 1'b1);
                       chk("B halted pc", pa, 8'h03);
                       chk("B halted we", we, 1'b0);
                       chk("B halted out", outb, 16'd3);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_instruction_sequencer
`default_nettype wire

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Control/fetch stage directly upstream of the ALU in the Harvard machine.
- Fetches 16-bit instructions from program ROM and decodes them into operand code, output selector and memory address.
- Reads data memory, presents operands to the ALU and holds them for a fixed execute window.
- Commits ALU results to the PC, accumulator, condition flag, data memory or output register; halts on EOP.

Parameters:
- EXEC_CYCLES, 4, cycles operands are held stable before ALU outputs are sampled (min 3: covers both phase alignments of the free-running two-phase ALU).
- ADDR_W, 8, program/data address width.
- DATA_W, 16, data/accumulator width.

Ports:
- clkInput  in  1  system clock, rising edge
- rstInput  in  1  asynchronous, active-high reset
- InstructionInput  in  16  program ROM read data; valid 1 cycle after address
- ProgramAddressOutput  out  8  program ROM address (= PC)
- DataReadInput  in  16  data RAM read data; valid 1 cycle after address
- DataAddressOutput  out  8  data RAM address (= instr[7:0])
- DataWriteEnableOutput  out  1  one-cycle RAM write strobe
- DataWriteOutput  out  16  RAM write data
- OperandOutput  out  5  to ALU OperandInput
- OutputSelectorOutput  out  3  to ALU OutputSelectorInput
- AccumulatorReadOutput  out  16  accumulator value to ALU
- DataOperandOutput  out  16  latched RAM word to ALU DataReadInput
- ConditionFlagReadOutput  out  1  condition flag to ALU
- AluConditionFlagInput  in  1  ALU ConditionFlagWriteOutput
- AluEndFlagInput  in  1  ALU EndFlagWriteOutput
- AluProgramCounterInput  in  8  ALU ProgramCounterOutput
- AluAccumulatorInput  in  16  ALU AccumulatorWriteOutput
- AluDataInput  in  16  ALU DataWriteOutput
- AluOutputBinaryInput  in  16  ALU OutputBinaryOutput
- OutputBinaryOutput  out  16  7-segment display value register
- HaltOutput  out  1  high once EOP has executed

Behaviour:
- Instruction format: [15:11] opcode, [10:8] output selector, [7:0] data address.
- Reset, asynchronous, overrides everything:
  - PC=0, accumulator=0, condition flag=0, OutputBinary=0, HaltOutput=0.
  - DataWriteEnable=0, Operand=0 (NOP), OutputSelector=0.
  - State=FETCH.
  - Reset mid-instruction discards the instruction; no write is issued.
- FSM, one state per cycle unless noted:
  - FETCH: drive PC on ProgramAddressOutput -> FETCH_WAIT.
  - FETCH_WAIT: ROM latency -> DECODE.
  - DECODE: latch instruction; drive DataAddressOutput -> READ_WAIT.
  - READ_WAIT: latch DataReadInput into the operand register -> EXEC.
  - EXEC: drive opcode/selector/operands constant for exactly EXEC_CYCLES cycles (counter), then -> COMMIT.
  - COMMIT: one cycle; then -> HALT if opcode 00100, else FETCH.
  - HALT: all outputs frozen, no strobes, exit only by reset.
- Outside EXEC, OperandOutput=0 and OutputSelectorOutput=0, so the ALU computes NOP.
- COMMIT actions:
  - Selector 001: accumulator <= AluAccumulatorInput.
  - Selector 011: DataWriteEnable=1 for this cycle only; DataWriteOutput=AluDataInput; address = instr[7:0].
  - Selector 100: OutputBinary <= AluOutputBinaryInput.
  - Selector 010 (JUMP 01100, BEQ 01101, BNE 01110): PC <= AluProgramCounterInput when taken. JUMP is always taken; BEQ is taken when flag=1; BNE when flag=0. Not taken: PC <= PC+1.
  - Selectors 000, 101-111: no register write.
  - Opcodes LT 01000 and GT 01001: flag <= AluConditionFlagInput; other opcodes leave the flag unchanged.
  - All non-branch instructions: PC <= PC+1, mod 256 (255 wraps to 0).
  - EOP: HaltOutput <= 1, PC unchanged.
- Latency: 5 + EXEC_CYCLES cycles per instruction (9 at default).
- Unknown opcodes execute as NOP (PC+1).

Decomposition:
- Shared package: opcode constants (NOP, PRINT, LOAD, STORE, EOP, LT, GT, JUMP, BEQ, BNE, ADD..AND), selector constants (SEL_NONE/ACC/PC/MEM/SEG), FSM state enum, instruction field offsets.
- One sub-module, exec_timer: loadable down-counter producing a done pulse after EXEC_CYCLES; used by the EXEC state.

Test Plan:
- Reset mid-EXEC with the selector at MEM -> no DataWriteEnable pulse; PC=0, Acc=0; first fetch from address 0 two cycles after release.
- ROM[0]=ADD/ACC/addr 5, RAM[5]=7, Acc=3, ALU model returns 10 -> Acc=10 at COMMIT; PC=1; 9 cycles per instruction.
- STORE/MEM addr 0x20, AluData=0xBEEF -> single-cycle write strobe, address 0x20, data 0xBEEF.
- LT sets flag=1; then BEQ with ALU PC=0x40 -> PC=0x40. Same sequence with flag=0 -> PC=old+1. BNE mirrors.
- PC=0xFF executing NOP -> next fetch from address 0x00.
- EOP at PC=3 -> HaltOutput=1; PC stays 3; no further ROM address changes or write strobes for 100 cycles.
